// File: rtl/bram_read_streamer_if.sv
// Valid/ready word stream with last-beat marker carried out of bram_read_streamer.
interface bram_read_streamer_if;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/bram_read_streamer.sv
// Burst read engine: issues BRAM reads, absorbs the 1-cycle read latency and streams words out.
// Optional BRAM_STREAM_CHECKSUM_EN adds a wrapping 16-bit checksum of accepted words.
module bram_read_streamer #(
  parameter int NUM_BLOCKS = 16,
  localparam int ADDR_W = 8 + $clog2(NUM_BLOCKS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [ADDR_W:0]         length,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [15:0]             rd_data,
  bram_read_streamer_if.master    m
`ifdef BRAM_STREAM_CHECKSUM_EN
  ,
  output logic [15:0]             checksum
`endif
);

  localparam int unsigned        DEPTH     = 256 * NUM_BLOCKS;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]    CNT_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]   beat_cnt_q, beat_cnt_d;
  logic              inflight_q, inflight_d;
  logic [15:0]       fifo_mem_q [2];
  logic [15:0]       fifo_mem_d [2];
  logic              fifo_wp_q, fifo_wp_d;
  logic              fifo_rp_q, fifo_rp_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic        fifo_empty, m_valid_w, pop, pop_fifo, push, issue;
  logic [15:0] m_data_w;
  logic [2:0]  occ_after;

  // The RAM output register acts as the FIFO's bypass slot: a word still sitting on
  // rd_data is presented directly and only copied into the FIFO if it is not taken.
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign m_valid_w  = !fifo_empty || inflight_q;
  assign m_data_w   = !m_valid_w ? 16'h0000 : (fifo_empty ? rd_data : fifo_mem_q[fifo_rp_q]);
  assign pop        = m_valid_w && m.m_ready;
  assign pop_fifo   = pop && !fifo_empty;
  assign push       = inflight_q && !(pop && fifo_empty);
  assign occ_after  = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == S_RUN) && (issue_cnt_q != '0) && (occ_after < 3'd2);

  assign m.m_valid = m_valid_w;
  assign m.m_data  = m_data_w;
  assign m.m_last  = m_valid_w && (beat_cnt_q == CNT_ONE);
  assign rd_en     = issue;
  assign rd_addr   = ptr_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    inflight_d  = issue;
    fifo_mem_d  = fifo_mem_q;
    fifo_wp_d   = fifo_wp_q;
    fifo_rp_d   = fifo_rp_q;
    fifo_cnt_d  = fifo_cnt_q + 2'(push) - 2'(pop_fifo);

    if (push) begin
      fifo_mem_d[fifo_wp_q] = rd_data;
      fifo_wp_d             = !fifo_wp_q;
    end
    if (pop_fifo) begin
      fifo_rp_d = !fifo_rp_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = S_RUN;
            ptr_d       = start_addr;
            issue_cnt_d = length;
            beat_cnt_d  = length;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          ptr_d       = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_ONE;
          issue_cnt_d = issue_cnt_q - CNT_ONE;
        end
        if (pop) begin
          beat_cnt_d = beat_cnt_q - CNT_ONE;
          if (beat_cnt_q == CNT_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      issue_cnt_q   <= '0;
      beat_cnt_q    <= '0;
      inflight_q    <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wp_q     <= 1'b0;
      fifo_rp_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
      fifo_mem_q  <= fifo_mem_d;
      fifo_wp_q   <= fifo_wp_d;
      fifo_rp_q   <= fifo_rp_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

`ifdef BRAM_STREAM_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == S_IDLE && start) begin
      checksum_d = '0;
    end else if (pop) begin
      checksum_d = checksum_q + m_data_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_bram_read_streamer.sv
// Directed bench for bram_read_streamer: per-cycle vector table plus hand-written corner sequences.
module tb_bram_read_streamer;
  localparam int ADDR_W = 12;

  typedef struct {
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
    logic              ready;
    logic              exp_busy;
    logic              exp_done;
    logic              exp_rd_en;
    logic [ADDR_W-1:0] exp_rd_addr;
    logic              exp_valid;
    logic [15:0]       exp_data;
    logic              exp_last;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              busy, done, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data = 16'h0000;
  logic [15:0]       mem [4096];
`ifdef BRAM_STREAM_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  bram_read_streamer_if s ();

  bram_read_streamer #(.NUM_BLOCKS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m          (s)
`ifdef BRAM_STREAM_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Block RAM model with one-cycle registered read; it has no reset on purpose.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic st, logic [ADDR_W-1:0] a, logic [ADDR_W:0] l, logic rdy,
                              logic b, logic d, logic re, logic [ADDR_W-1:0] ra,
                              logic mv, logic [15:0] md, logic ml);
    vec_t v;
    v.start = st; v.addr = a; v.len = l; v.ready = rdy;
    v.exp_busy = b; v.exp_done = d; v.exp_rd_en = re; v.exp_rd_addr = ra;
    v.exp_valid = mv; v.exp_data = md; v.exp_last = ml;
    return v;
  endfunction

  task automatic drive(input logic st, input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] l, input logic rdy);
    @(posedge clk); #1;
    start = st; start_addr = a; length = l; s.m_ready = rdy;
  endtask

  initial begin
    int cyc, issued, popped, stall_re, done_cnt, rd_cnt;
    logic done_seen, prev_stalled;
    logic [15:0] prev_data;
    logic [15:0] got[$];

    for (int i = 0; i < 4096; i++) mem[i] = i[15:0];
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; s.m_ready = 1'b0;

    // Steady stream at 0x010, wrap across the top address, and a zero-length burst.
    tbl.push_back(mk(1, 12'h010, 13'd4, 1, 0, 0, 0, 12'h000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 1, 12'h010, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 1, 12'h011, 1, 16'h0010, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 1, 12'h012, 1, 16'h0011, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 1, 12'h013, 1, 16'h0012, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 0, 12'h000, 1, 16'h0013, 1));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 0, 1, 0, 12'h000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 0, 0, 0, 12'h000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 12'hFFE, 13'd4, 1, 0, 0, 0, 12'h000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 1, 12'hFFE, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 1, 12'hFFF, 1, 16'h0FFE, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 1, 12'h000, 1, 16'h0FFF, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 1, 12'h001, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 1, 0, 0, 12'h000, 1, 16'h0001, 1));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 0, 1, 0, 12'h000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 0, 0, 0, 12'h000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 12'h123, 13'd0, 1, 0, 0, 0, 12'h000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 0, 1, 0, 12'h000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 12'h000, 13'd0, 1, 0, 0, 0, 12'h000, 0, 16'h0000, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_m_valid", s.m_valid, 0);
    chk("reset_m_last", s.m_last, 0);
    chk("reset_m_data", s.m_data, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].addr, tbl[i].len, tbl[i].ready);
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("v%0d_done", i), done, tbl[i].exp_done);
      chk($sformatf("v%0d_rd_en", i), rd_en, tbl[i].exp_rd_en);
      if (tbl[i].exp_rd_en) chk($sformatf("v%0d_rd_addr", i), rd_addr, tbl[i].exp_rd_addr);
      chk($sformatf("v%0d_m_valid", i), s.m_valid, tbl[i].exp_valid);
      chk($sformatf("v%0d_m_last", i), s.m_last, tbl[i].exp_last);
      if (tbl[i].exp_valid) chk($sformatf("v%0d_m_data", i), s.m_data, tbl[i].exp_data);
    end

    // Backpressure: ready toggles, then a 5-cycle stall in cycles 6..10.
    drive(1, 12'h100, 13'd8, 0);
    cyc = 0; issued = 0; popped = 0; stall_re = 0; done_seen = 0; prev_stalled = 0; prev_data = '0;
    got.delete();
    while (!done_seen && cyc < 80) begin
      @(negedge clk);
      if (rd_en) issued++;
      if (cyc >= 6 && cyc <= 10 && rd_en) stall_re++;
      if (prev_stalled) begin
        chk("bp_hold_valid", s.m_valid, 1);
        chk("bp_hold_data", s.m_data, prev_data);
      end
      if (s.m_valid) chk("bp_last", s.m_last, (got.size() == 7));
      if (s.m_valid && s.m_ready) begin
        got.push_back(s.m_data);
        popped++;
      end
      chk("bp_outstanding", ((issued - popped) <= 2), 1);
      prev_stalled = s.m_valid && !s.m_ready;
      prev_data = s.m_data;
      if (done) done_seen = 1'b1;
      cyc++;
      drive(0, '0, '0, (cyc >= 6 && cyc <= 10) ? 1'b0 : 1'(cyc % 2));
    end
    chk("bp_done_seen", done_seen, 1);
    chk("bp_word_count", got.size(), 8);
    chk("bp_stall_rd_en_le2", (stall_re <= 2), 1);
    chk("bp_issued", issued, 8);
    foreach (got[i]) chk($sformatf("bp_word%0d", i), got[i], 16'h0100 + 16'(i));

    // start while busy must be ignored.
    drive(1, 12'h020, 13'd3, 1);
    got.delete(); done_cnt = 0; rd_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (s.m_valid && s.m_ready) got.push_back(s.m_data);
      if (c == 1) drive(1, 12'h200, 13'd5, 1);
      else drive(0, '0, '0, 1);
    end
    chk("busy_start_words", got.size(), 3);
    chk("busy_start_rd_en", rd_cnt, 3);
    chk("busy_start_done", done_cnt, 1);
    foreach (got[i]) chk($sformatf("busy_start_word%0d", i), got[i], 16'h0020 + 16'(i));

    // Reset with one read in flight; the late RAM word must not surface.
    drive(1, 12'h300, 13'd6, 0);
    drive(0, '0, '0, 0);
    @(negedge clk);
    chk("rst_pre_rd_en", rd_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_m_valid", s.m_valid, 0);
    chk("rst_m_last", s.m_last, 0);
    chk("rst_m_data", s.m_data, 0);
    @(negedge clk);
    chk("rst_no_stale_valid", s.m_valid, 0);
    drive(1, 12'h050, 13'd2, 1);
    drive(0, '0, '0, 1);
    drive(0, '0, '0, 1);
    @(negedge clk);
    chk("post_rst_valid0", s.m_valid, 1);
    chk("post_rst_word0", s.m_data, 16'h0050);
    drive(0, '0, '0, 1);
    @(negedge clk);
    chk("post_rst_word1", s.m_data, 16'h0051);
    chk("post_rst_last1", s.m_last, 1);
    drive(0, '0, '0, 1);
    @(negedge clk);
    chk("post_rst_done", done, 1);

`ifdef BRAM_STREAM_CHECKSUM_EN
    for (int i = 0; i < 3; i++) mem[i] = 16'hFFFF;
    drive(1, 12'h000, 13'd3, 1);
    drive(0, '0, '0, 1);
    @(negedge clk);
    chk("cks_cleared", checksum, 0);
    done_seen = 0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      drive(0, '0, '0, 1);
      @(negedge clk);
      if (done) begin
        done_seen = 1'b1;
        chk("cks_at_done", checksum, 16'hFFFD);
      end
    end
    chk("cks_done_seen", done_seen, 1);
    drive(0, '0, '0, 1);
    @(negedge clk);
    chk("cks_held", checksum, 16'hFFFD);
    for (int i = 0; i < 3; i++) mem[i] = i[15:0];
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
